// File: rtl/demux_stream_pkg.sv
// Shared types and constants for the registered 1:N stream demultiplexer.
package demux_stream_pkg;

  // Occupancy of a channel's one-entry output slot.
  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  // Width of each per-channel drain counter (optional statistics build).
  localparam int STATS_COUNT_WIDTH = 16;

endpackage

// File: rtl/demux_stream_slot.sv
// One-entry output slot of the stream demultiplexer.
// Optional drain counter is built when DEMUX_STREAM_STATS_EN is defined.
module demux_stream_slot
  import demux_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  ready,
  output slot_state_t           state,
  output logic [DATA_WIDTH-1:0] data
`ifdef DEMUX_STREAM_STATS_EN
  ,
  output logic [STATS_COUNT_WIDTH-1:0] count
`endif
);

  slot_state_t state_next;
  logic        drain;

  assign drain = (state == SLOT_FULL) && ready;

  // Slot occupancy register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SLOT_EMPTY;
    else        state <= state_next;
  end

  // Next occupancy: a load always wins, a drain alone empties the slot.
  always_comb begin
    state_next = state;
    case (state)
      SLOT_EMPTY: if (load)           state_next = SLOT_FULL;
      SLOT_FULL:  if (drain && !load) state_next = SLOT_EMPTY;
      default:                        state_next = SLOT_EMPTY;
    endcase
  end

  // Payload register: replaced on load, cleared when drained without refill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     data <= '0;
    else if (load)  data <= load_data;
    else if (drain) data <= '0;
  end

`ifdef DEMUX_STREAM_STATS_EN
  // Count every drain; wraps naturally at the counter width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     count <= '0;
    else if (drain) count <= count + 1'b1;
  end
`endif

endmodule

// File: rtl/demux_stream_1_n.sv
// Registered 1:N stream demultiplexer with per-channel one-entry slots.
// Define DEMUX_STREAM_STATS_EN to add Transfer_Count_Out (16-bit drain
// counter per channel).
//
// Handshake: a beat moves on a rising edge when valid and ready are both
// high on that interface; Ready_Out never depends on Valid_In, and an
// output's Valid_Out stays high until its consumer takes the beat.
module demux_stream_1_n
  import demux_stream_pkg::*;
#(
  parameter  int DATA_WIDTH   = 8,
  parameter  int NUM_CHANNELS = 4,
  localparam int SEL_WIDTH    = $clog2(NUM_CHANNELS)
) (
  input  logic                               Clock_In,
  input  logic                               Reset_n_In,
  input  logic                               Enable_In,
  input  logic                               Valid_In,
  output logic                               Ready_Out,
  input  logic [DATA_WIDTH-1:0]              Data_In,
  input  logic [SEL_WIDTH-1:0]               Select_In,
  output logic [NUM_CHANNELS-1:0]            Valid_Out,
  input  logic [NUM_CHANNELS-1:0]            Ready_In,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0] Data_Out,
  output logic                               Error_Out
`ifdef DEMUX_STREAM_STATS_EN
  ,
  output logic [NUM_CHANNELS*STATS_COUNT_WIDTH-1:0] Transfer_Count_Out
`endif
);

  localparam logic [SEL_WIDTH:0] CHANNEL_LIMIT = (SEL_WIDTH+1)'(NUM_CHANNELS);

  slot_state_t                slot_state [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0]    sel_hot;
  logic [NUM_CHANNELS-1:0]    drain;
  logic [NUM_CHANNELS-1:0]    load;
  logic                       sel_in_range;
  logic                       slot_open;
  logic                       transfer;

  // One-hot decode of the destination; all-zero for an out-of-range select.
  always_comb begin
    sel_hot = '0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      if (Select_In == SEL_WIDTH'(k)) sel_hot[k] = 1'b1;
    end
  end

  assign sel_in_range = {1'b0, Select_In} < CHANNEL_LIMIT;
  assign drain        = Valid_Out & Ready_In;
  // Selected slot can take a beat if empty or emptying on this same edge.
  assign slot_open    = |(sel_hot & (~Valid_Out | drain));
  // Out-of-range beats are accepted so they can be discarded.
  assign Ready_Out    = Enable_In && (!sel_in_range || slot_open);
  assign transfer     = Valid_In && Ready_Out;
  assign load         = transfer ? sel_hot : '0;

  // Flag a discarded out-of-range beat for exactly one cycle.
  always_ff @(posedge Clock_In or negedge Reset_n_In) begin
    if (!Reset_n_In) Error_Out <= 1'b0;
    else             Error_Out <= transfer && !sel_in_range;
  end

  for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_slot
    demux_stream_slot #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_slot (
      .clk       (Clock_In),
      .rst_n     (Reset_n_In),
      .load      (load[k]),
      .load_data (Data_In),
      .ready     (Ready_In[k]),
      .state     (slot_state[k]),
      .data      (Data_Out[k*DATA_WIDTH +: DATA_WIDTH])
`ifdef DEMUX_STREAM_STATS_EN
      ,
      .count     (Transfer_Count_Out[k*STATS_COUNT_WIDTH +: STATS_COUNT_WIDTH])
`endif
    );

    assign Valid_Out[k] = (slot_state[k] == SLOT_FULL);
  end

endmodule

// File: tb/tb_demux_stream_1_n.sv
// Bench for demux_stream_1_n with five channels (select values 5..7 are
// out of range). Checks counters too when DEMUX_STREAM_STATS_EN is defined.
module tb_demux_stream_1_n;

  localparam int DW = 8;
  localparam int NC = 5;
  localparam int SW = $clog2(NC);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic              en, vin, rdy;
  logic [DW-1:0]     din;
  logic [SW-1:0]     sel;
  logic [NC-1:0]     vout, rin;
  logic [NC*DW-1:0]  dout;
  logic              err;
`ifdef DEMUX_STREAM_STATS_EN
  logic [NC*16-1:0]  tcnt;
`endif

  demux_stream_1_n #(
    .DATA_WIDTH  (DW),
    .NUM_CHANNELS(NC)
  ) dut (
    .Clock_In   (clk),
    .Reset_n_In (rst_n),
    .Enable_In  (en),
    .Valid_In   (vin),
    .Ready_Out  (rdy),
    .Data_In    (din),
    .Select_In  (sel),
    .Valid_Out  (vout),
    .Ready_In   (rin),
    .Data_Out   (dout),
    .Error_Out  (err)
`ifdef DEMUX_STREAM_STATS_EN
    ,
    .Transfer_Count_Out(tcnt)
`endif
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference model: each channel is a box holding at most one beat.
  bit          m_full [NC];
  logic [DW-1:0] m_data [NC];
  bit          m_err;
  int unsigned m_cnt  [NC];

  task automatic model_reset();
    for (int k = 0; k < NC; k++) begin
      m_full[k] = 0; m_data[k] = '0; m_cnt[k] = 0;
    end
    m_err = 0;
  endtask

  function automatic logic model_ready();
    int s = int'(sel);
    if (!en)      return 1'b0;
    if (s >= NC)  return 1'b1;
    return !m_full[s] || rin[s];
  endfunction

  task automatic model_edge(input bit xfer);
    int s = int'(sel);
    for (int k = 0; k < NC; k++) begin
      if (m_full[k] && rin[k]) begin
        m_full[k] = 0;
        m_data[k] = '0;
        m_cnt[k]  = (m_cnt[k] + 1) % 65536;
      end
    end
    if (xfer && s < NC) begin
      m_full[s] = 1;
      m_data[s] = din;
    end
    m_err = xfer && (s >= NC);
  endtask

  task automatic check_outputs();
    logic [NC-1:0]    ev;
    logic [NC*DW-1:0] ed;
    ev = '0; ed = '0;
    for (int k = 0; k < NC; k++) begin
      ev[k] = m_full[k];
      ed[k*DW +: DW] = m_data[k];
    end
    check("ready", rdy, model_ready());
    check("valid", vout, ev);
    check("data", dout, ed);
    check("error", err, m_err);
`ifdef DEMUX_STREAM_STATS_EN
    begin
      logic [NC*16-1:0] ec;
      ec = '0;
      for (int k = 0; k < NC; k++) ec[k*16 +: 16] = m_cnt[k][15:0];
      check("count", tcnt, ec);
    end
`endif
  endtask

  // ---------------- driver ----------------
  // Drive one cycle: apply inputs on the falling edge, check, then step
  // the model across the following rising edge.
  task automatic cycle(input logic e, input logic v, input logic [DW-1:0] d,
                       input logic [SW-1:0] s, input logic [NC-1:0] r,
                       output logic rdy_seen);
    bit xfer;
    @(negedge clk);
    en = e; vin = v; din = d; sel = s; rin = r;
    #1;
    check_outputs();
    rdy_seen = rdy;
    xfer = v && model_ready();
    @(posedge clk);
    model_edge(xfer);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic r_seen;
    logic hold;
    logic e, v;
    logic [DW-1:0] d;
    logic [SW-1:0] s;
    logic [NC-1:0] r;

    rst_n = 1'b0; en = 1'b1; vin = 1'b0; din = '0; sel = '0; rin = '0;
    model_reset();
    #12;
    check("rst_valid", vout, '0);
    check("rst_data", dout, '0);
    check("rst_error", err, 1'b0);
    check("rst_ready_en1", rdy, 1'b1);
    en = 1'b0; #1;
    check("rst_ready_en0", rdy, 1'b0);
    #4 rst_n = 1'b1;

    // Route one beat to channel 2.
    cycle(1, 1, 8'hA5, 2, '0, r_seen);
    check("route_valid", vout, 5'b00100);
    check("route_data", dout, 40'h00_00_A5_00_00);
    vin = 1'b0; sel = 2; #1;
    check("route_ready_sel2", rdy, 1'b0);
    sel = 0; #1;
    check("route_ready_sel0", rdy, 1'b1);

    // Back-to-back stream to channel 1 with its consumer always ready.
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(DW'(i));
      cycle(1, 1, DW'(i), 1, 5'b00010, r_seen);
      check("stream_ready", r_seen, 1'b1);
      check("stream_data", dout[15:8], exp_q.pop_front());
    end

    // Back-pressure on channel 3.
    cycle(1, 1, 8'h3C, 3, '0, r_seen);
    cycle(1, 1, 8'h77, 3, '0, r_seen);
    check("bp_ready_low", r_seen, 1'b0);
    cycle(1, 1, 8'h77, 3, '0, r_seen);
    check("bp_held_data", dout[31:24], 8'h3C);
    cycle(1, 1, 8'h77, 3, 5'b01000, r_seen);
    check("bp_ready_drain", r_seen, 1'b1);
    check("bp_new_data", dout[31:24], 8'h77);
    check("bp_still_valid", vout[3], 1'b1);

    // Enable low: nothing accepted, channel 2 still drains.
    cycle(0, 1, 8'h11, 0, 5'b00100, r_seen);
    check("en_low_ready", r_seen, 1'b0);
    check("en_low_no_load", vout[0], 1'b0);
    check("en_low_drain", vout[2], 1'b0);

    // Out-of-range select: accepted, discarded, one-cycle error pulse.
    cycle(1, 1, 8'hEE, 5, '0, r_seen);
    check("oor_ready", r_seen, 1'b1);
    check("oor_error", err, 1'b1);
    check("oor_no_ch0", vout[0], 1'b0);
    cycle(1, 0, 8'h00, 0, '0, r_seen);
    check("oor_error_clear", err, 1'b0);

    // Five drains of channel 0.
    for (int i = 0; i < 5; i++) cycle(1, 1, DW'(8'h50 + i), 0, 5'b00001, r_seen);
    cycle(1, 0, 8'h00, 0, 5'b00001, r_seen);
`ifdef DEMUX_STREAM_STATS_EN
    check("count_ch0_five", tcnt[15:0], 16'd5);
`endif

    // Asynchronous reset with slots full.
    cycle(1, 1, 8'h42, 4, '0, r_seen);
    cycle(1, 1, 8'h43, 2, '0, r_seen);
    @(negedge clk);
    vin = 1'b0; en = 1'b1; rin = '0; #2;
    rst_n = 1'b0; #1;
    check("arst_valid", vout, '0);
    check("arst_data", dout, '0);
    check("arst_error", err, 1'b0);
    check("arst_ready", rdy, 1'b1);
`ifdef DEMUX_STREAM_STATS_EN
    check("arst_count", tcnt, '0);
`endif
    model_reset();
    #1 rst_n = 1'b1;

    // Randomized traffic, producer holds a stalled beat stable.
    hold = 1'b0; d = '0; s = '0;
    for (int n = 0; n < 600; n++) begin
      e = ($urandom_range(0, 9) != 0);
      r = NC'($urandom_range(0, (1 << NC) - 1));
      if (hold) begin
        v = 1'b1;
      end else begin
        v = ($urandom_range(0, 3) != 0);
        d = DW'($urandom_range(0, 255));
        s = SW'($urandom_range(0, 7));
      end
      cycle(e, v, d, s, r, r_seen);
      hold = v && !r_seen;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
